// File: rtl/cla_share_arbiter_pkg.sv
// Shared constants, operand-slice macro and elaboration helpers for the
// shared carry-lookahead adder arbiter.
`ifndef CLA_SLICE
`define CLA_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package cla_share_arbiter_pkg;

    localparam int CLA_WIDTH_DEFAULT = 11;

    // Constant function usable in parameter defaults and elaboration checks.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nbit_carrylookahead.sv
// Parameterised carry-lookahead adder: every carry is formed directly from
// the generate/propagate terms of the bits below it.
module nbit_carrylookahead #(
    parameter int WIDTH = 11
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is rebuilt from cin and the g/p terms, so synthesis sees a
    // flat sum-of-products per bit rather than a chain of previous carries.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            acc = cin;
            for (int j = 0; j <= i; j++) begin
                acc = gen[j] | (prop[j] & acc);
            end
            carry[i+1] = acc;
        end
    end

    assign sum  = prop ^ carry[WIDTH-1:0];
    assign cout = carry[WIDTH];

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first set request at or after ptr, wrapping,
// and returns it one-hot and encoded.
module rr_pick
    import cla_share_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before the search loop, so no
        // path through the block leaves a value held and no latch is inferred.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/cla_share_arbiter.sv
// Shares one carry-lookahead adder between NREQ requesters with round-robin
// arbitration and a single-entry registered result port.
module cla_share_arbiter
    import cla_share_arbiter_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH_DEFAULT,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id
);

    if (IDW != clog2(NREQ)) begin : g_idw_check
        $error("cla_share_arbiter: IDW must equal clog2(NREQ)");
    end

    logic [IDW-1:0]   ptr;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   g;
    logic             any_req;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (g),
        .any   (any_req)
    );

    // A full register can still take a new result if it drains this cycle.
    assign can_accept = ~rsp_valid | rsp_ready;
    assign accept     = ~rst & any_req & can_accept;
    assign req_ready  = accept ? grant : '0;

    assign op_a = `CLA_SLICE(req_a, g, WIDTH);
    assign op_b = `CLA_SLICE(req_b, g, WIDTH);

    nbit_carrylookahead #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // NOTE: all state uses non-blocking assignment so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
            ptr       <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
            rsp_id    <= g;
            ptr       <= (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Directed, table-driven bench for cla_share_arbiter (WIDTH=11, NREQ=4).
module tb_cla_share_arbiter;

    localparam int WIDTH = 11;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic [IDW-1:0]        rsp_id;

    cla_share_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock: inputs driven after negedge, outputs checked
    // before the following posedge (expected values reflect pre-edge state).
    typedef struct {
        logic            rst;
        logic [NREQ-1:0] valid;
        logic            rsp_ready;
        logic [NREQ-1:0] exp_ready;
        logic            exp_valid;
        logic            chk_data;
        logic [WIDTH-1:0] exp_sum;
        logic            exp_cout;
        logic [IDW-1:0]  exp_id;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input logic r, input logic [NREQ-1:0] v, input logic rr,
                                input logic [NREQ-1:0] er, input logic ev, input logic cd,
                                input logic [WIDTH-1:0] es, input logic ec, input logic [IDW-1:0] ei);
        vec_t t;
        t.rst = r;  t.valid = v;  t.rsp_ready = rr;
        t.exp_ready = er;  t.exp_valid = ev;  t.chk_data = cd;
        t.exp_sum = es;  t.exp_cout = ec;  t.exp_id = ei;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int i);
        @(negedge clk);
        rst       = v.rst;
        req_valid = v.valid;
        rsp_ready = v.rsp_ready;
        #2;
        check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(v.exp_ready));
        check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(v.exp_valid));
        if (v.chk_data) begin
            check($sformatf("v%0d rsp_sum", i),  32'(rsp_sum),  32'(v.exp_sum));
            check($sformatf("v%0d rsp_cout", i), 32'(rsp_cout), 32'(v.exp_cout));
            check($sformatf("v%0d rsp_id", i),   32'(rsp_id),   32'(v.exp_id));
        end
    endtask

    task automatic drive(input logic r, input logic [NREQ-1:0] v, input logic rr);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        rsp_ready = rr;
        #2;
    endtask

    initial begin
        // Fixed operands: sums 30, 123, 2048 (->0,c=1), 2100 (->52,c=1).
        req_a = {11'd2000, 11'd2047, 11'd100, 11'd10};
        req_b = {11'd100,  11'd1,    11'd23,  11'd20};
        rst = 1'b1;
        req_valid = 4'b0110;
        rsp_ready = 1'b1;

        //               rst   valid    rr    exp_rdy  ev    chk   sum       cout  id
        vecs[0]  = mk(1'b1, 4'b1011, 1'b1, 4'b0000, 1'b0, 1'b1, 11'd0,   1'b0, 2'd0);
        vecs[1]  = mk(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 11'd0,   1'b0, 2'd0);
        vecs[2]  = mk(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b1, 11'd0,   1'b0, 2'd0);
        vecs[3]  = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 11'd0,   1'b1, 2'd2);
        vecs[4]  = mk(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b0, 1'b0, 11'd0,   1'b0, 2'd0);
        vecs[5]  = mk(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 11'd52,  1'b1, 2'd3);
        vecs[6]  = mk(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 11'd30,  1'b0, 2'd0);
        vecs[7]  = mk(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 11'd123, 1'b0, 2'd1);
        vecs[8]  = mk(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 11'd0,   1'b1, 2'd2);
        vecs[9]  = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 11'd52,  1'b1, 2'd3);
        vecs[10] = mk(1'b0, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b0, 11'd0,   1'b0, 2'd0);
        for (int i = 11; i <= 15; i++)
            vecs[i] = mk(1'b0, 4'b1001, 1'b0, 4'b0000, 1'b1, 1'b1, 11'd123, 1'b0, 2'd1);
        vecs[16] = mk(1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 1'b1, 11'd123, 1'b0, 2'd1);
        vecs[17] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 11'd52,  1'b1, 2'd3);
        vecs[18] = mk(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 11'd0,   1'b0, 2'd0);
        vecs[19] = mk(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 11'd30,  1'b0, 2'd0);
        vecs[20] = mk(1'b0, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b1, 11'd30,  1'b0, 2'd0);
        vecs[21] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 11'd123, 1'b0, 2'd1);

        @(posedge clk);
        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        // Reset mid-stream: ptr is 2 here, so requester 1 is granted.
        drive(1'b0, 4'b0010, 1'b0);
        check("mid req_ready", 32'(req_ready), 32'h2);
        drive(1'b0, 4'b0000, 1'b0);
        check("mid held valid", 32'(rsp_valid), 32'h1);
        check("mid held sum", 32'(rsp_sum), 32'd123);
        check("mid held id", 32'(rsp_id), 32'd1);
        drive(1'b1, 4'b1111, 1'b0);
        check("mid rst req_ready", 32'(req_ready), 32'h0);
        // After reset the pointer must restart at 0, even though it was 2.
        drive(1'b0, 4'b1111, 1'b0);
        check("post rst valid", 32'(rsp_valid), 32'h0);
        check("post rst sum", 32'(rsp_sum), 32'd0);
        check("post rst cout", 32'(rsp_cout), 32'd0);
        check("post rst id", 32'(rsp_id), 32'd0);
        check("post rst req_ready", 32'(req_ready), 32'h1);
        drive(1'b0, 4'b0000, 1'b1);
        check("post rst result valid", 32'(rsp_valid), 32'h1);
        check("post rst result sum", 32'(rsp_sum), 32'd30);
        check("post rst result id", 32'(rsp_id), 32'd0);
        drive(1'b0, 4'b0000, 1'b1);
        check("post rst drained", 32'(rsp_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
